store_buffer: RTL and testbench

Memory-side receiver for store operations issued by the store reservation station. The block queues issued stores in program order and holds each one until the reorder buffer commits its tag. It then writes committed stores to data memory through a request/acknowledge handshake and reports completion to the ROB by pulsing the store's tag. It sits between the store RS and the data-memory port.

---
 rtl/store_pkg.sv | 26 ++
 rtl/store_lane_gen.sv | 36 +++
 rtl/store_buffer.sv | 198 +++++++++++++++++++
 tb/tb_store_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared constants, FSM states and queue entry type for the store buffer
package store_pkg;

    localparam int ROB_W = 6;
    localparam logic [ROB_W-1:0] INVALID_ROB = 6'b010000;

    localparam logic [2:0] SB_OP = 3'b000;
    localparam logic [2:0] SH_OP = 3'b001;
    localparam logic [2:0] SW_OP = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wr_state_t;

    typedef struct packed {
        logic             valid;
        logic             committed;
        logic [ROB_W-1:0] rob;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [2:0]       sub_type;
    } sb_entry_t;

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - byte-enable and lane-replicated write data for one store
module store_lane_gen
    import store_pkg::*;
(
    input  logic [2:0]  sub_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    // Replicate the store value across every lane it could land in and enable only the target lanes.
    always_comb begin
        be    = 4'b0000;
        wdata = data;
        case (sub_type)
            SB_OP: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{data[7:0]}};
            end
            SH_OP: begin
                be    = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
            end
            SW_OP: begin
                be    = 4'b1111;
                wdata = data;
            end
            default: begin
                be    = 4'b0000;
                wdata = data;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue with commit gating and memory write FSM; STORE_FWD_EN enables load forwarding
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             storeEnable,
    input  logic [ROB_W-1:0] robNum_in,
    input  logic [31:0]      data1_in,
    input  logic [31:0]      data2_in,
    input  logic [2:0]       subType_in,
    output logic             full,
    input  logic             commitEnable,
    input  logic [ROB_W-1:0] commitRob,
    input  logic             flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    output logic             iscast,
    output logic [ROB_W-1:0] robNum_out,
    input  logic [31:0]      fwd_addr,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] n_comm;
    wr_state_t        state;
    wr_state_t        state_d;
    logic             do_pop;
    logic             do_enq;
    logic             start_wr;
    sb_entry_t        head_e;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;

    assign head_e = entries[head];

    store_lane_gen u_lane_gen (
        .sub_type (head_e.sub_type),
        .byte_off (head_e.addr[1:0]),
        .data     (head_e.data),
        .be       (lane_be),
        .wdata    (lane_wdata)
    );

    // Committed entries always form a prefix from head, so their count gives the post-flush tail.
    always_comb begin
        n_comm = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && entries[i].committed) begin
                n_comm = n_comm + 1'b1;
            end
        end
    end

    // Write FSM next state: start on a committed head, pop on ack, one completion cycle.
    always_comb begin
        state_d  = state;
        do_pop   = 1'b0;
        start_wr = 1'b0;
        case (state)
            IDLE: begin
                if (head_e.valid && head_e.committed) begin
                    state_d  = WRITE;
                    start_wr = 1'b1;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    do_pop  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A pop frees the slot the tail points at when full, so enqueue may proceed; flush drops the new store.
    always_comb begin
        do_enq = storeEnable && !flush && (!full || do_pop);
        if (flush) begin
            count_d = n_comm - CNT_W'(do_pop);
        end else begin
            count_d = count + CNT_W'(do_enq) - CNT_W'(do_pop);
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Queue storage: commit marking, flush invalidation, pop, then enqueue so a same-slot enqueue wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commitEnable && entries[i].valid && !entries[i].committed &&
                    entries[i].rob == commitRob) begin
                    entries[i].committed <= 1'b1;
                end
                if (flush && entries[i].valid && !entries[i].committed) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (do_pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (do_enq) begin
                entries[tail] <= '{valid: 1'b1, committed: 1'b0, rob: robNum_in,
                                   addr: data2_in, data: data1_in, sub_type: subType_in};
            end
            if (flush) begin
                tail <= head + PTR_W'(n_comm);
            end else if (do_enq) begin
                tail <= tail + 1'b1;
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Memory-side outputs: latched from the head at write start, completion tag shown only in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            iscast     <= 1'b0;
            robNum_out <= INVALID_ROB;
        end else begin
            mem_req <= (state_d == WRITE);
            iscast  <= (state_d == DONE);
            if (start_wr) begin
                mem_addr  <= {head_e.addr[31:2], 2'b00};
                mem_wdata <= lane_wdata;
                mem_be    <= lane_be;
            end
            robNum_out <= do_pop ? head_e.rob : INVALID_ROB;
        end
    end

`ifdef STORE_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest matching full-word store is the one reported.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (entries[fwd_idx].valid && entries[fwd_idx].sub_type == SW_OP &&
                entries[fwd_idx].addr[31:2] == fwd_addr[31:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[fwd_idx].data;
            end
        end
    end
`else
    logic unused_fwd_addr;

    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed and randomized checks of store_buffer against a queue model
module tb_store_buffer;
    import store_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        storeEnable = 1'b0;
    logic [5:0]  robNum_in = '0;
    logic [31:0] data1_in = '0;
    logic [31:0] data2_in = '0;
    logic [2:0]  subType_in = '0;
    logic        full;
    logic        commitEnable = 1'b0;
    logic [5:0]  commitRob = '0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        iscast;
    logic [5:0]  robNum_out;
    logic [31:0] fwd_addr = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .storeEnable  (storeEnable),
        .robNum_in    (robNum_in),
        .data1_in     (data1_in),
        .data2_in     (data2_in),
        .subType_in   (subType_in),
        .full         (full),
        .commitEnable (commitEnable),
        .commitRob    (commitRob),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .iscast       (iscast),
        .robNum_out   (robNum_out),
        .fwd_addr     (fwd_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  rob;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  st;
        bit          committed;
    } m_t;

    m_t mq[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [3:0] exp_be(input logic [2:0] st, input logic [31:0] a);
        logic [3:0] b;
        b = 4'b0000;
        case (st)
            3'd0: b[a[1:0]] = 1'b1;
            3'd1: b = (a[1] == 1'b1) ? 4'b1100 : 4'b0011;
            3'd2: b = 4'b1111;
            default: b = 4'b0000;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] st, input logic [31:0] d);
        case (st)
            3'd0: return {24'h0, d[7:0]} * 32'h01010101;
            3'd1: return {16'h0, d[15:0]} * 32'h00010001;
            default: return d;
        endcase
    endfunction

    task automatic issue(input logic [5:0] r, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] st);
        storeEnable = 1'b1;
        robNum_in   = r;
        data2_in    = a;
        data1_in    = d;
        subType_in  = st;
        @(negedge clock);
        storeEnable = 1'b0;
        if (mq.size() < DEPTH) mq.push_back('{rob: r, addr: a, data: d, st: st, committed: 1'b0});
    endtask

    task automatic commit(input logic [5:0] r);
        commitEnable = 1'b1;
        commitRob    = r;
        @(negedge clock);
        commitEnable = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].rob == r && !mq[i].committed) begin
                mq[i].committed = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_flush();
        m_t keep[$];
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        keep = {};
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].committed) keep.push_back(mq[i]);
        end
        mq = keep;
    endtask

    // Serve the oldest model entry: expect its write, ack after dly cycles, expect the completion pulse.
    task automatic serve_next(input string tag, input int dly);
        m_t e;
        int waited;
        e = mq[0];
        waited = 0;
        while (mem_req !== 1'b1 && waited < 30) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_req"}, mem_req, 1);
        if (mem_req === 1'b1) begin
            check({tag, "_addr"}, mem_addr, e.addr & ~32'h3);
            check({tag, "_be"}, mem_be, exp_be(e.st, e.addr));
            if (e.st <= 3'd2) check({tag, "_wdata"}, mem_wdata, exp_wd(e.st, e.data));
            repeat (dly) @(negedge clock);
            if (dly > 0) check({tag, "_req_hold"}, mem_req, 1);
            mem_ack = 1'b1;
            @(negedge clock);
            mem_ack = 1'b0;
            check({tag, "_iscast"}, iscast, 1);
            check({tag, "_robout"}, robNum_out, e.rob);
            check({tag, "_req_drop"}, mem_req, 0);
            @(negedge clock);
            check({tag, "_iscast_pulse"}, iscast, 0);
        end
        void'(mq.pop_front());
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0 && mq[0].committed) serve_next(tag, $urandom_range(0, 2));
        repeat (4) @(negedge clock);
        check({tag, "_idle_req"}, mem_req, 0);
        check({tag, "_full"}, full, (mq.size() == DEPTH) ? 1 : 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_iscast", iscast, 0);
        check("rst_robout", robNum_out, 6'b010000);
        check("rst_full", full, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        check("rst_fwd_data", fwd_data, 0);
        reset = 1'b0;
        @(negedge clock);

        // Basic word store with a two-cycle memory wait.
        issue(6'd3, 32'h100, 32'hDEADBEEF, 3'd2);
        commit(6'd3);
        serve_next("sw", 2);

        // Byte and halfword lane steering.
        issue(6'd5, 32'h203, 32'h00000055, 3'd0);
        commit(6'd5);
        serve_next("sb", 0);
        issue(6'd6, 32'h202, 32'h00001234, 3'd1);
        commit(6'd6);
        serve_next("sh", 1);

        // Fill, overflow drop, in-order drain.
        for (int i = 1; i <= 4; i++) issue(6'(i), 32'h1000 + 32'(i * 4), 32'(i * 17), 3'd2);
        check("fill_full", full, 1);
        issue(6'd5, 32'h2000, 32'h5555, 3'd2);
        check("over_full", full, 1);
        for (int i = 1; i <= 5; i++) commit(6'(i));
        drain("inorder");

        // Flush keeps only the committed prefix; a new store lands at the post-flush tail.
        issue(6'd1, 32'h400, 32'h11, 3'd2);
        issue(6'd2, 32'h404, 32'h22, 3'd2);
        issue(6'd3, 32'h408, 32'h33, 3'd2);
        commit(6'd1);
        do_flush();
        drain("flush");
        commit(6'd2);
        commit(6'd3);
        drain("flush_stale");
        issue(6'd7, 32'h300, 32'h77, 3'd2);
        commit(6'd7);
        drain("post_flush");

        // Randomized batches against the queue model.
        for (int it = 0; it < 30; it++) begin
            int n;
            int k;
            bit fl;
            logic [5:0] base;
            n = $urandom_range(1, 5);
            base = 6'(8 * (it % 8));
            fl = ($urandom_range(0, 1) == 1);
            k = fl ? $urandom_range(0, n - 1) : n;
            for (int i = 0; i < n; i++)
                issue(base + 6'(i + 1), $urandom, $urandom, 3'($urandom_range(0, 3)));
            for (int i = 0; i < k; i++) commit(base + 6'(i + 1));
            if (fl) do_flush();
            drain("rand");
        end

        // Reset in the middle of a write abandons it with no completion.
        issue(6'd9, 32'h500, 32'h99, 3'd2);
        commit(6'd9);
        for (int w = 0; w < 10 && mem_req !== 1'b1; w++) @(negedge clock);
        check("midwr_req", mem_req, 1);
        reset = 1'b1;
        #1;
        check("midwr_rst_req", mem_req, 0);
        check("midwr_rst_robout", robNum_out, 6'b010000);
        check("midwr_rst_iscast", iscast, 0);
        mq = {};
        @(negedge clock);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("after_rst_iscast", iscast, 0);
        check("after_rst_req", mem_req, 0);

        // Forwarding query against two same-word stores.
        issue(6'd1, 32'h40, 32'h1, 3'd2);
        issue(6'd2, 32'h40, 32'h2, 3'd2);
        issue(6'd3, 32'h80, 32'h3, 3'd0);
        fwd_addr = 32'h42;
        #1;
`ifdef STORE_FWD_EN
        check("fwd_hit", fwd_hit, 1);
        check("fwd_data", fwd_data, 2);
        fwd_addr = 32'h80;
        #1;
        check("fwd_sb_nohit", fwd_hit, 0);
`else
        check("fwd_off_hit", fwd_hit, 0);
        check("fwd_off_data", fwd_data, 0);
`endif
        @(negedge clock);
        do_flush();
        fwd_addr = 32'h40;
        #1;
        check("fwd_after_flush", fwd_hit, 0);
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
